wave_monitor: RTL
=================

# wave_monitor

Checker and decoder for the 6-bit LED wave bus produced by the wave generators (`wave_right` and similar). It samples the LED pattern on the same clock and recovers the lit position and the direction of travel. It counts completed sweeps, flags illegal patterns and stalled waves, and reports the tracking status. It sits beside the generator in simulation and on the board, driving debug outputs and bench assertions.

## Interface
- `WIDTH`, 6: number of LED lines observed; minimum 2.
- `TIMEOUT`, 24: consecutive unchanged cycles in TRACK before a stall is declared; minimum 2.
- `POS_W`, derived: `$clog2(WIDTH)`; not overridable.

- `clk`  in  1  system clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-low reset.
- `led_in`  in  WIDTH  LED pattern from the generator, same clock domain, active-high (bit set = LED lit).
- `pos`  out  POS_W  index of the currently lit LED.
- `dir`  out  1  last observed direction: 0 = right (index decreasing), 1 = left (index increasing).
- `valid`  out  1  high while the monitor is locked (TRACK or STALL).
- `err`  out  1  one-cycle pulse on an illegal pattern or transition.
- `stall`  out  1  high while in STALL.
- `sweep_count`  out  8  number of wrap-arounds; saturates at 255.
- `err_count`  out  8  number of `err` pulses; saturates at 255.

## Operation
- Input stage: `led_q <= led_in` every cycle. All decisions use `led_q`.
- One-hot check: `led_q` is legal only if exactly one bit is set. All-zero and multi-hot patterns are illegal.
- Reset (`rst`=0 at a clock edge): state=SYNC, `led_q`=0, `pos`=0, `dir`=0, `valid`=0, `err`=0, `stall`=0, both counters=0, hold counter=0. Reset mid-operation clears everything, counters included.
- **SYNC**
  - `valid`=0.
  - If `led_q` is one-hot: load `pos`, clear the hold counter, go to TRACK. `dir` is unchanged.
  - Otherwise stay in SYNC with no `err`.
- **TRACK** compares `led_q` against one-hot(`pos`):
  - Equal: hold. Increment the hold counter. When it reaches TIMEOUT, go to STALL.
  - Bit `pos-1` with `pos`>0: `pos`--, `dir`=0.
  - Bit `pos+1` with `pos`<WIDTH-1: `pos`++, `dir`=1.
  - `pos`=0 and bit WIDTH-1: `pos`=WIDTH-1, `dir`=0, `sweep_count`++.
  - `pos`=WIDTH-1 and bit 0: `pos`=0, `dir`=1, `sweep_count`++.
  - Anything else (zero, multi-hot, jump of ≥2 positions): `err`=1 for one cycle, `err_count`++, go to SYNC. `pos` and `dir` hold their last values.
  - Every legal move clears the hold counter.
- **STALL**
  - `stall`=1, `valid`=1.
  - Equal pattern: stay in STALL; the hold counter saturates.
  - Legal move: apply the TRACK move rules and return to TRACK with `stall`=0.
  - Illegal pattern: apply the TRACK error rules and go to SYNC with `stall`=0.
- Reversal at an interior position (e.g. 3→2→3) is legal. It updates `dir` and does not count as a sweep.
- `err` and a sweep increment never occur in the same cycle.

## Timing
- `led_in` to `led_q`: 1 cycle. `led_q` to registered outputs: 1 cycle. Total latency is 2 cycles from an `led_in` change to `pos`, `dir`, `valid`, `err`, `stall`, and the counters.
- `valid` rises 2 cycles after the first one-hot `led_in` that follows reset release or an error.
- After an error, `valid`=0 for at least one cycle. If `led_q` is already one-hot on that cycle, re-lock happens on the next cycle.
- `stall` rises on the cycle the hold count reaches TIMEOUT. That is 1 + TIMEOUT + 1 cycles after the last `led_in` change.
- `stall` falls 2 cycles after the next legal `led_in` change.
- All outputs are registered; there are no combinational paths from `led_in`.

## Test plan
- Reset: hold `rst`=0 for 3 cycles with `led_in`=100000. All outputs are 0 during reset. After release, `valid`=1 and `pos`=5 two cycles later, and `err`=0.
- Right sweep: step `led_in` 100000→010000→…→000001→100000, one step every 4 cycles. `pos` follows 5,4,3,2,1,0,5 and `dir`=0 throughout. `sweep_count`=1 after the wrap; `err_count`=0; `stall` never rises.
- Left motion and interior reversal: 000001→000010→000100→000010. `dir` goes 1, 1, then 0 and `pos` follows 1, 2, 1. `sweep_count` is unchanged.
- Illegal jump: lock at 000100, then drive 010000. `err` pulses for exactly one cycle, `err_count`=1, and `valid`=0 for one cycle. Then `valid`=1 with `pos`=4. Repeat with 000000: `err_count`=2, and `valid` stays 0 while the input stays zero.
- Stall: hold 000100 for 30 cycles with TIMEOUT=24. `stall` is 1 from the 26th cycle after the last change and `valid` stays 1. Then drive 000010: `stall`=0 and `pos`=1 two cycles later.
- Mid-operation reset: after one sweep and one error, pulse `rst`=0 for 1 cycle. `sweep_count`, `err_count`, `pos`, `dir`, and `valid` all read 0 on the next cycle.

Source files
------------

// File: rtl/wave_monitor.sv
// rtl/wave_monitor.sv - checker and decoder for the one-hot LED wave bus
//
// Samples the LED pattern driven by a wave generator, recovers the lit
// position and direction of travel, counts sweeps (wrap-arounds), flags
// illegal patterns or jumps, and detects a wave that has stopped moving.
//
// Ports:
//   clk          system clock, rising edge
//   rst          synchronous active-low reset
//   led_in       LED pattern, active-high, same clock domain
//   pos          index of the currently lit LED
//   dir          last direction: 0 = index decreasing, 1 = index increasing
//   valid        locked onto the wave (TRACK or STALL)
//   err          one-cycle pulse on an illegal pattern or transition
//   stall        wave has not moved for TIMEOUT cycles
//   sweep_count  wrap-arounds seen, saturating at 255
//   err_count    err pulses seen, saturating at 255

module wave_monitor #(
  parameter int WIDTH = 6,
  parameter int TIMEOUT = 24,
  localparam int POS_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] led_in,
  output logic [POS_W-1:0] pos,
  output logic             dir,
  output logic             valid,
  output logic             err,
  output logic             stall,
  output logic [7:0]       sweep_count,
  output logic [7:0]       err_count
);

  localparam int HOLD_W = $clog2(TIMEOUT + 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(TIMEOUT);
  localparam logic [POS_W-1:0] POS_MAX = POS_W'(WIDTH - 1);
  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  typedef enum logic [1:0] {
    SYNC  = 2'd0,
    TRACK = 2'd1,
    STALL = 2'd2
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [WIDTH-1:0]  led_q;
  logic [HOLD_W-1:0] hold;
  logic [HOLD_W-1:0] hold_nxt;
  logic [POS_W-1:0]  pos_nxt;
  logic              dir_nxt;
  logic              err_nxt;
  logic              sweep_inc;

  logic              is_onehot;
  logic [POS_W-1:0]  led_idx;
  logic              at_pos;
  logic              mv_dn;
  logic              mv_up;
  logic              wrap_dn;
  logic              wrap_up;

  // Index of the highest set bit; only meaningful when led_q is one-hot.
  always_comb begin
    led_idx = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (led_q[i]) led_idx = POS_W'(i);
    end
  end

  assign is_onehot = ($countones(led_q) == 1);

  // Candidate moves relative to the tracked position. The pos guards keep
  // the shifted masks in range; for WIDTH=2 mv_up wins over wrap_dn below.
  assign at_pos  = (led_q == (ONE << pos));
  assign mv_dn   = (pos != '0) && (led_q == (ONE << (pos - 1'b1)));
  assign mv_up   = (pos != POS_MAX) && (led_q == (ONE << (pos + 1'b1)));
  assign wrap_dn = (pos == '0) && (led_q == (ONE << POS_MAX));
  assign wrap_up = (pos == POS_MAX) && (led_q == ONE);

  always_comb begin
    state_nxt = state;
    pos_nxt   = pos;
    dir_nxt   = dir;
    hold_nxt  = hold;
    err_nxt   = 1'b0;
    sweep_inc = 1'b0;
    case (state)
      SYNC: begin
        if (is_onehot) begin
          pos_nxt   = led_idx;
          hold_nxt  = '0;
          state_nxt = TRACK;
        end
      end
      TRACK, STALL: begin
        if (at_pos) begin
          // Saturating hold count; reaching the limit enters (or keeps) STALL.
          if (hold != HOLD_MAX) hold_nxt = hold + 1'b1;
          if (hold_nxt == HOLD_MAX) state_nxt = STALL;
        end else if (mv_dn) begin
          pos_nxt   = pos - 1'b1;
          dir_nxt   = 1'b0;
          hold_nxt  = '0;
          state_nxt = TRACK;
        end else if (mv_up) begin
          pos_nxt   = pos + 1'b1;
          dir_nxt   = 1'b1;
          hold_nxt  = '0;
          state_nxt = TRACK;
        end else if (wrap_dn) begin
          pos_nxt   = POS_MAX;
          dir_nxt   = 1'b0;
          hold_nxt  = '0;
          sweep_inc = 1'b1;
          state_nxt = TRACK;
        end else if (wrap_up) begin
          pos_nxt   = '0;
          dir_nxt   = 1'b1;
          hold_nxt  = '0;
          sweep_inc = 1'b1;
          state_nxt = TRACK;
        end else begin
          // Zero, multi-hot or a jump: drop lock, keep last pos/dir.
          err_nxt   = 1'b1;
          state_nxt = SYNC;
        end
      end
      default: begin
        state_nxt = SYNC;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= SYNC;
      led_q       <= '0;
      pos         <= '0;
      dir         <= 1'b0;
      hold        <= '0;
      err         <= 1'b0;
      sweep_count <= 8'd0;
      err_count   <= 8'd0;
    end else begin
      state <= state_nxt;
      led_q <= led_in;
      pos   <= pos_nxt;
      dir   <= dir_nxt;
      hold  <= hold_nxt;
      err   <= err_nxt;
      if (sweep_inc && (sweep_count != 8'hFF)) sweep_count <= sweep_count + 8'd1;
      if (err_nxt && (err_count != 8'hFF)) err_count <= err_count + 8'd1;
    end
  end

  // Decoded straight from the state register, so still registered outputs.
  assign valid = (state != SYNC);
  assign stall = (state == STALL);

endmodule
